// File: rtl/pong_game_sm_param.sv
// Pong game controller: holds game state, ball kinematics, paddle positions
// and scores. Motion advances only on the one-cycle frame_tick strobe.
module pong_game_sm_param #(
    parameter int FIELD_W       = 640,
    parameter int FIELD_H       = 480,
    parameter int PADDLE_W      = 8,
    parameter int PADDLE_H      = 64,
    parameter int PADDLE_OFFSET = 16,
    parameter int BALL_SIZE     = 8,
    parameter int PADDLE_SPEED  = 4,
    parameter int BALL_SPEED_X  = 2,
    parameter int BALL_SPEED_Y  = 2,
    parameter int SERVE_DELAY   = 60,
    parameter int WIN_SCORE     = 9
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_game,
    input  logic       pause,
    input  logic [1:0] player_left_input,
    input  logic [1:0] player_right_input,
    output logic [9:0] ball_pos_x,
    output logic [9:0] ball_pos_y,
    output logic [9:0] player_left_pos,
    output logic [9:0] player_right_pos,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic       game_running,
    output logic       game_over_signal,
    output logic       point_scored,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        POINT     = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    // Geometry is widened to 11 bits so sums near the field edge never wrap.
    localparam logic [10:0] BALL_CX      = 11'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [10:0] BALL_CY      = 11'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [10:0] PAD_CENTRE   = 11'((FIELD_H - PADDLE_H) / 2);
    localparam logic [10:0] PAD_MAX      = 11'(FIELD_H - PADDLE_H);
    localparam logic [10:0] PAD_SPEED    = 11'(PADDLE_SPEED);
    localparam logic [10:0] PAD_HEIGHT   = 11'(PADDLE_H);
    localparam logic [10:0] BALL_SZ      = 11'(BALL_SIZE);
    localparam logic [10:0] SPEED_X      = 11'(BALL_SPEED_X);
    localparam logic [10:0] SPEED_Y      = 11'(BALL_SPEED_Y);
    localparam logic [10:0] FIELD_HEIGHT = 11'(FIELD_H);
    localparam logic [10:0] LEFT_PLANE   = 11'(PADDLE_OFFSET + PADDLE_W);
    localparam logic [10:0] RIGHT_PLANE  = 11'(FIELD_W - PADDLE_OFFSET - PADDLE_W - BALL_SIZE);
    localparam logic [15:0] SERVE_LAST   = 16'((SERVE_DELAY > 0) ? SERVE_DELAY - 1 : 0);
    localparam logic [3:0]  WIN          = 4'(WIN_SCORE);

    state_t      state_q, state_d;
    logic [9:0]  ball_x, ball_y, pad_l, pad_r;
    logic        dir_left, dir_down;
    logic [3:0]  score_l, score_r;
    logic [15:0] serve_cnt;
    logic        left_scored;

    logic [10:0] ball_x_ext, ball_y_ext, pad_l_ext, pad_r_ext;
    logic [9:0]  ball_x_nxt, ball_y_nxt, pad_l_nxt, pad_r_nxt;
    logic        dir_left_nxt, dir_down_nxt, miss_left, miss_right;
    logic [3:0]  scorer_total;
    logic        running_d, over_d, point_d;

    function automatic logic [9:0] paddle_step(input logic [9:0] pos, input logic [1:0] dir);
        logic [10:0] p;
        logic [10:0] r;
        p = {1'b0, pos};
        r = p;
        if (dir == 2'b10)
            r = (p <= PAD_SPEED) ? 11'd0 : p - PAD_SPEED;
        else if (dir == 2'b01)
            r = (p + PAD_SPEED >= PAD_MAX) ? PAD_MAX : p + PAD_SPEED;
        return 10'(r);
    endfunction

    function automatic logic overlaps(input logic [10:0] y, input logic [10:0] p);
        return (y + BALL_SZ > p) && (y < p + PAD_HEIGHT);
    endfunction

    assign ball_x_ext   = {1'b0, ball_x};
    assign ball_y_ext   = {1'b0, ball_y};
    assign pad_l_ext    = {1'b0, pad_l};
    assign pad_r_ext    = {1'b0, pad_r};
    assign pad_l_nxt    = paddle_step(pad_l, player_left_input);
    assign pad_r_nxt    = paddle_step(pad_r, player_right_input);
    assign scorer_total = left_scored ? score_l + 4'd1 : score_r + 4'd1;

    // Candidate ball position for this frame, using pre-update ball and paddles.
    always_comb begin
        ball_x_nxt   = ball_x;
        ball_y_nxt   = ball_y;
        dir_left_nxt = dir_left;
        dir_down_nxt = dir_down;
        miss_left    = 1'b0;
        miss_right   = 1'b0;
        if (dir_down) begin
            if (ball_y_ext + BALL_SZ + SPEED_Y >= FIELD_HEIGHT) begin
                ball_y_nxt   = 10'(FIELD_HEIGHT - BALL_SZ);
                dir_down_nxt = 1'b0;
            end else begin
                ball_y_nxt = 10'(ball_y_ext + SPEED_Y);
            end
        end else begin
            if (ball_y_ext <= SPEED_Y) begin
                ball_y_nxt   = 10'd0;
                dir_down_nxt = 1'b1;
            end else begin
                ball_y_nxt = 10'(ball_y_ext - SPEED_Y);
            end
        end
        if (dir_left) begin
            if (ball_x_ext <= LEFT_PLANE + SPEED_X) begin
                if (overlaps(ball_y_ext, pad_l_ext)) begin
                    ball_x_nxt   = 10'(LEFT_PLANE);
                    dir_left_nxt = 1'b0;
                end else begin
                    miss_left = 1'b1;
                end
            end else begin
                ball_x_nxt = 10'(ball_x_ext - SPEED_X);
            end
        end else begin
            if (ball_x_ext + SPEED_X >= RIGHT_PLANE) begin
                if (overlaps(ball_y_ext, pad_r_ext)) begin
                    ball_x_nxt   = 10'(RIGHT_PLANE);
                    dir_left_nxt = 1'b1;
                end else begin
                    miss_right = 1'b1;
                end
            end else begin
                ball_x_nxt = 10'(ball_x_ext + SPEED_X);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; pause takes priority over a coincident frame tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_game) state_d = SERVE;
            SERVE:     if (frame_tick && serve_cnt >= SERVE_LAST) state_d = PLAY;
            PLAY: begin
                if (pause)                                     state_d = PAUSE;
                else if (frame_tick && (miss_left || miss_right)) state_d = POINT;
            end
            PAUSE:     if (pause) state_d = PLAY;
            POINT:     state_d = (scorer_total == WIN) ? GAME_OVER : SERVE;
            GAME_OVER: if (start_game) state_d = SERVE;
            default:   state_d = IDLE;
        endcase
    end

    // Status flags are decoded from the next state so they line up with state.
    always_comb begin
        running_d = (state_d == SERVE) || (state_d == PLAY) || (state_d == PAUSE);
        over_d    = (state_d == GAME_OVER);
        point_d   = (state_d == POINT);
    end

    // Registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            game_running     <= 1'b0;
            game_over_signal <= 1'b0;
            point_scored     <= 1'b0;
        end else begin
            game_running     <= running_d;
            game_over_signal <= over_d;
            point_scored     <= point_d;
        end
    end

    // Ball, paddle, score and serve-timer updates for each state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ball_x      <= 10'(BALL_CX);
            ball_y      <= 10'(BALL_CY);
            pad_l       <= 10'(PAD_CENTRE);
            pad_r       <= 10'(PAD_CENTRE);
            dir_left    <= 1'b1;
            dir_down    <= 1'b1;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            serve_cnt   <= 16'd0;
            left_scored <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_game) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        serve_cnt <= 16'd0;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        pad_l     <= pad_l_nxt;
                        pad_r     <= pad_r_nxt;
                        serve_cnt <= serve_cnt + 16'd1;
                    end
                end
                PLAY: begin
                    if (frame_tick && !pause) begin
                        pad_l    <= pad_l_nxt;
                        pad_r    <= pad_r_nxt;
                        ball_x   <= ball_x_nxt;
                        ball_y   <= ball_y_nxt;
                        dir_left <= dir_left_nxt;
                        dir_down <= dir_down_nxt;
                        if (miss_left || miss_right) left_scored <= miss_right;
                    end
                end
                POINT: begin
                    if (left_scored) score_l <= scorer_total;
                    else             score_r <= scorer_total;
                    ball_x    <= 10'(BALL_CX);
                    ball_y    <= 10'(BALL_CY);
                    dir_left  <= ~left_scored;
                    dir_down  <= 1'b1;
                    serve_cnt <= 16'd0;
                end
                GAME_OVER: begin
                    if (start_game) begin
                        score_l   <= 4'd0;
                        score_r   <= 4'd0;
                        pad_l     <= 10'(PAD_CENTRE);
                        pad_r     <= 10'(PAD_CENTRE);
                        serve_cnt <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ball_pos_x       = ball_x;
    assign ball_pos_y       = ball_y;
    assign player_left_pos  = pad_l;
    assign player_right_pos = pad_r;
    assign score_left       = score_l;
    assign score_right      = score_r;
    assign state            = state_q;

endmodule

// File: tb/tb_pong_game_sm_param.sv
// Self-checking bench for pong_game_sm_param on a small 40x20 field.
module tb_pong_game_sm_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_game = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] player_left_input = 2'b00;
    logic [1:0] player_right_input = 2'b00;
    logic [9:0] ball_pos_x, ball_pos_y, player_left_pos, player_right_pos;
    logic [3:0] score_left, score_right;
    logic       game_running, game_over_signal, point_scored;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       ft;
        logic       sg;
        logic       ps;
        logic [1:0] li;
        logic [1:0] ri;
        int st, bx, by, pl, pr, sl, sr, run, ov, pt;
    } vec_t;

    vec_t vecs[$];

    pong_game_sm_param #(
        .FIELD_W(40), .FIELD_H(20), .PADDLE_W(2), .PADDLE_H(4), .PADDLE_OFFSET(2),
        .BALL_SIZE(4), .PADDLE_SPEED(1), .BALL_SPEED_X(1), .BALL_SPEED_Y(1),
        .SERVE_DELAY(2), .WIN_SCORE(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .frame_tick(frame_tick),
        .start_game(start_game),
        .pause(pause),
        .player_left_input(player_left_input),
        .player_right_input(player_right_input),
        .ball_pos_x(ball_pos_x),
        .ball_pos_y(ball_pos_y),
        .player_left_pos(player_left_pos),
        .player_right_pos(player_right_pos),
        .score_left(score_left),
        .score_right(score_right),
        .game_running(game_running),
        .game_over_signal(game_over_signal),
        .point_scored(point_scored),
        .state(state)
    );

    // 100 MHz system clock.
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ft, input logic sg, input logic ps,
                                input logic [1:0] li, input logic [1:0] ri,
                                input int st, input int bx, input int by, input int pl, input int pr,
                                input int sl, input int sr, input int run, input int ov, input int pt);
        vec_t v;
        v.ft = ft; v.sg = sg; v.ps = ps; v.li = li; v.ri = ri;
        v.st = st; v.bx = bx; v.by = by; v.pl = pl; v.pr = pr;
        v.sl = sl; v.sr = sr; v.run = run; v.ov = ov; v.pt = pt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        checks++;
        if (actual !== 32'(expected)) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected value -1 marks a field that is not checked at this point.
    task automatic checkAll(input string tag, input int st, input int bx, input int by,
                            input int pl, input int pr, input int sl, input int sr,
                            input int run, input int ov, input int pt);
        if (st >= 0)  checkOutput({tag, ".state"}, 32'(state), st);
        if (bx >= 0)  checkOutput({tag, ".ball_x"}, 32'(ball_pos_x), bx);
        if (by >= 0)  checkOutput({tag, ".ball_y"}, 32'(ball_pos_y), by);
        if (pl >= 0)  checkOutput({tag, ".pad_l"}, 32'(player_left_pos), pl);
        if (pr >= 0)  checkOutput({tag, ".pad_r"}, 32'(player_right_pos), pr);
        if (sl >= 0)  checkOutput({tag, ".score_l"}, 32'(score_left), sl);
        if (sr >= 0)  checkOutput({tag, ".score_r"}, 32'(score_right), sr);
        if (run >= 0) checkOutput({tag, ".running"}, 32'(game_running), run);
        if (ov >= 0)  checkOutput({tag, ".over"}, 32'(game_over_signal), ov);
        if (pt >= 0)  checkOutput({tag, ".point"}, 32'(point_scored), pt);
    endtask

    // Drive one clock worth of inputs, then settle just after the edge.
    task automatic applyStimulus(input logic ft, input logic sg, input logic ps,
                                 input logic [1:0] li, input logic [1:0] ri);
        frame_tick = ft;
        start_game = sg;
        pause = ps;
        player_left_input = li;
        player_right_input = ri;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start_game = 1'b0;
        pause = 1'b0;
    endtask

    // Hard stop in case the run overruns its cycle budget.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        // Serve, paddle motion and saturation, first PLAY ticks, a left miss and the re-serve.
        vecs.push_back(mk(0,1,0,2'b00,2'b00, 1,18, 8,8, 8,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b00, 1,18, 8,7, 8,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,18, 8,6, 9,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,17, 9,5,10,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,2'b10,2'b01, 2,17, 9,5,10,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,16,10,4,11,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b11,2'b00, 2,15,11,4,11,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,14,12,3,12,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,13,13,2,13,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,12,14,1,14,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,11,15,0,15,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b10,2'b01, 2,10,16,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b11,2'b11, 2, 9,15,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,1,0,2'b00,2'b00, 2, 8,14,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 2, 7,13,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 2, 6,12,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 2, 5,11,0,16,0,0,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 4,-1,-1,0,16,-1,-1,0,0,1));
        vecs.push_back(mk(0,0,0,2'b00,2'b00, 1,18, 8,0,16,0,1,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 1,18, 8,0,16,0,1,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 2,18, 8,0,16,0,1,1,0,0));
        vecs.push_back(mk(1,0,0,2'b00,2'b00, 2,17, 9,0,16,0,1,1,0,0));

        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 2'b00, 2'b00);
        checkAll("reset", 0, 18, 8, 8, 8, 0, 0, 0, 0, 0);

        $display("[TB] vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].ft, vecs[i].sg, vecs[i].ps, vecs[i].li, vecs[i].ri);
            checkAll($sformatf("vec%0d", i), vecs[i].st, vecs[i].bx, vecs[i].by, vecs[i].pl,
                     vecs[i].pr, vecs[i].sl, vecs[i].sr, vecs[i].run, vecs[i].ov, vecs[i].pt);
        end

        $display("[TB] async reset mid-game, left hit and right miss");
        reset_n = 1'b0;
        #2;
        checkAll("async_reset", 0, 18, 8, 8, 8, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 1, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        checkAll("b_serve_done", 2, 18, 8, 8, 8, 0, 0, 1, 0, 0);
        for (int t = 1; t <= 42; t++) begin
            applyStimulus(1, 0, 0, 2'b00, 2'b00);
            case (t)
                8:  checkAll("b_t8",  2, 10, 16, 8, 8, 0, 0, 1, 0, 0);
                9:  checkAll("b_t9",  2,  9, 15, 8, 8, 0, 0, 1, 0, 0);
                14: checkAll("b_t14", 2,  4, 10, 8, 8, 0, 0, 1, 0, 0);
                15: checkAll("b_t15", 2,  5,  9, 8, 8, 0, 0, 1, 0, 0);
                24: checkAll("b_t24", 2, 14,  0, 8, 8, 0, 0, 1, 0, 0);
                40: checkAll("b_t40", 2, 30, 16, 8, 8, 0, 0, 1, 0, 0);
                41: checkAll("b_t41", 2, 31, 15, 8, 8, 0, 0, 1, 0, 0);
                42: checkAll("b_t42", 4, -1, -1, 8, 8, -1, -1, 0, 0, 1);
                default: ;
            endcase
        end
        applyStimulus(0, 0, 0, 2'b00, 2'b00);
        checkAll("b_after_point", 1, 18, 8, 8, 8, 1, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        checkAll("b_serve_right", 2, 19, 9, 8, 8, 1, 0, 1, 0, 0);

        $display("[TB] pause, repeated misses and game over");
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 1, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        applyStimulus(1, 0, 0, 2'b00, 2'b00);
        checkAll("c_play1", 2, 17, 9, 8, 8, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 1, 2'b10, 2'b00);
        checkAll("c_pause", 3, 17, 9, 8, 8, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, (i == 2), 0, 2'b10, 2'b01);
            checkAll($sformatf("c_frozen%0d", i), 3, 17, 9, 8, 8, 0, 0, 1, 0, 0);
        end
        applyStimulus(0, 0, 1, 2'b10, 2'b00);
        checkAll("c_resume", 2, 17, 9, 8, 8, 0, 0, 1, 0, 0);
        for (int t = 2; t <= 14; t++) begin
            applyStimulus(1, 0, 0, 2'b10, 2'b00);
            if (t == 13) checkAll("c_t13", 2, 5, 11, 0, 8, 0, 0, 1, 0, 0);
        end
        checkAll("c_point1", 4, -1, -1, 0, 8, -1, -1, 0, 0, 1);
        applyStimulus(0, 0, 0, 2'b10, 2'b00);
        checkAll("c_after1", 1, 18, 8, 0, 8, 0, 1, 1, 0, 0);
        for (int p = 2; p <= 3; p++) begin
            applyStimulus(1, 0, 1, 2'b10, 2'b00);
            checkAll($sformatf("c_serve_pause%0d", p), 1, 18, 8, 0, 8, 0, p - 1, 1, 0, 0);
            applyStimulus(1, 0, 0, 2'b10, 2'b00);
            checkAll($sformatf("c_play%0d", p), 2, 18, 8, 0, 8, 0, p - 1, 1, 0, 0);
            for (int t = 1; t <= 14; t++) applyStimulus(1, 0, 0, 2'b10, 2'b00);
            checkAll($sformatf("c_point%0d", p), 4, -1, -1, 0, 8, -1, -1, 0, 0, 1);
            applyStimulus(0, 0, 0, 2'b10, 2'b00);
            if (p == 2) checkAll("c_after2", 1, 18, 8, 0, 8, 0, 2, 1, 0, 0);
            else        checkAll("c_game_over", 5, 18, 8, 0, 8, 0, 3, 0, 1, 0);
        end
        applyStimulus(1, 0, 1, 2'b01, 2'b10);
        checkAll("c_over_frozen", 5, 18, 8, 0, 8, 0, 3, 0, 1, 0);
        applyStimulus(0, 1, 0, 2'b00, 2'b00);
        checkAll("c_restart", 1, 18, 8, 8, 8, 0, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pong_game_sm_param.md
Name: pong_game_sm_param

Overview:
- Parametrised next-generation Pong game controller. It holds the game state, ball kinematics, paddle positions and scores for both players.
- It runs on the single system clock and advances motion only on a one-cycle frame_tick strobe from the VGA timing block.
- Field size, object sizes, speeds, serve delay and winning score are set by parameters; the previous design used port-driven geometry.
- New relative to game_sm: pause/resume, timed serve, configurable speeds and win score, and a point_scored pulse for the sound/score display blocks.

Parameters:
- FIELD_W, 640, playfield width in pixels.
- FIELD_H, 480, playfield height in pixels.
- PADDLE_W, 8, paddle width.
- PADDLE_H, 64, paddle height.
- PADDLE_OFFSET, 16, gap from side wall to paddle.
- BALL_SIZE, 8, ball edge length.
- PADDLE_SPEED, 4, paddle pixels per frame.
- BALL_SPEED_X, 2, ball horizontal pixels per frame.
- BALL_SPEED_Y, 2, ball vertical pixels per frame.
- SERVE_DELAY, 60, frame ticks spent in SERVE.
- WIN_SCORE, 9, points to win; range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-clk pulse per video frame.
- start_game  in  1  level; sampled in IDLE and GAME_OVER.
- pause  in  1  one-clk pulse; toggles PLAY/PAUSE.
- player_left_input  in  2  bit1=up, bit0=down.
- player_right_input  in  2  bit1=up, bit0=down.
- ball_pos_x  out  10  ball left edge.
- ball_pos_y  out  10  ball top edge.
- player_left_pos  out  10  left paddle top edge.
- player_right_pos  out  10  right paddle top edge.
- score_left  out  4  left player score.
- score_right  out  4  right player score.
- game_running  out  1  high in SERVE, PLAY or PAUSE.
- game_over_signal  out  1  high in GAME_OVER.
- point_scored  out  1  one-clk pulse when a point is awarded.
- state  out  3  IDLE=0, SERVE=1, PLAY=2, PAUSE=3, POINT=4, GAME_OVER=5.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; scores=0; point_scored=0.
  - Ball at ((FIELD_W-BALL_SIZE)/2, (FIELD_H-BALL_SIZE)/2).
  - Both paddles at (FIELD_H-PADDLE_H)/2.
  - Serve direction: dx=left, dy=down.
- All outputs are registered.
- IDLE:
  - start_game=1 -> SERVE; scores cleared; serve frame counter cleared.
- SERVE:
  - Ball held at centre.
  - Paddles move on frame_tick.
  - After SERVE_DELAY frame ticks -> PLAY.
- PLAY: on each frame_tick edge, paddles and ball update together using pre-update positions.
- Paddle update:
  - Input 10: pos -= PADDLE_SPEED, saturating at 0.
  - Input 01: pos += PADDLE_SPEED, saturating at FIELD_H-PADDLE_H.
  - Inputs 00 and 11: hold.
- Vertical wall:
  - Moving down with y+BALL_SIZE+BALL_SPEED_Y >= FIELD_H: y=FIELD_H-BALL_SIZE, dy flips.
  - Moving up with y <= BALL_SPEED_Y: y=0, dy flips.
  - Otherwise y steps by BALL_SPEED_Y.
- Overlap: ball overlaps paddle P when y+BALL_SIZE > P and y < P+PADDLE_H.
- Left side, moving left with x <= PADDLE_OFFSET+PADDLE_W+BALL_SPEED_X:
  - If overlapping left paddle: x=PADDLE_OFFSET+PADDLE_W, dx flips.
  - Else: miss; right player gains the point; next state POINT.
- Right side mirrors the left:
  - Hit plane is FIELD_W-PADDLE_OFFSET-PADDLE_W-BALL_SIZE.
  - A miss gives the point to the left player.
- Intermediate arithmetic uses 11 bits so no wrap-around occurs.
- POINT (one cycle):
  - Increment the scorer's score; point_scored=1 for this cycle only.
  - If the new score equals WIN_SCORE -> GAME_OVER; else -> SERVE.
  - Ball recentred; next serve dx points toward the player who conceded; dy=down.
- PAUSE:
  - Ball and paddles frozen.
  - pause pulse -> PLAY. No other exit.
- GAME_OVER:
  - Positions and scores frozen.
  - start_game=1 -> SERVE with scores cleared and paddles recentred.
- Simultaneous events:
  - pause and frame_tick in the same PLAY cycle: pause wins; no motion that frame.
  - start_game in SERVE, PLAY or PAUSE: ignored.
  - pause outside PLAY/PAUSE: ignored.
- Reset mid-game: immediate return to reset values regardless of state.

Test Plan:
Configuration for all scenarios: FIELD_W=40, FIELD_H=20, PADDLE_W=2, PADDLE_H=4, PADDLE_OFFSET=2, BALL_SIZE=4, both ball speeds 1, PADDLE_SPEED=1, SERVE_DELAY=2, WIN_SCORE=3.
1. Reset then release -> state=0, ball=(18,8), paddles=8, scores=0, game_running=0.
2. start_game 1 clk, then 2 frame ticks -> state=1 then 2; 1st PLAY tick gives ball=(17,9).
3. Left input 2'b10 held for 10 ticks -> player_left_pos 8,7,...,0, then holds at 0; 2'b11 holds position.
4. Paddles idle at 8 -> ball y reaches 16 after 8 PLAY ticks, then decreases; at the 14th tick x=4, y=10, dx flips; score unchanged.
5. Left input held at 10 from start -> miss near x=4 -> state=4 for 1 clk, point_scored=1, score_right=1, ball=(18,8), state=1, next serve dx=left.
6. Pause pulse in PLAY coincident with frame_tick -> state=3, positions frozen over 5 ticks; second pause -> PLAY. Third miss -> score_right=3, state=5, game_over_signal=1; start_game -> state=1, scores 0.
